// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
// Holds the fetch-entry layout, the redirect classification and the sequential-PC helper.
package if_prefetch_queue_pkg;

   localparam logic        CHIP_ENABLE  = 1'b1;
   localparam logic        CHIP_DISABLE = 1'b0;
   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
   localparam logic [31:0] PC_STEP      = 32'd4;
   localparam int          FETCHQ_DEPTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   typedef enum logic [2:0] {
      REDIR_NONE     = 3'd0,
      REDIR_FLUSH    = 3'd1,
      REDIR_BR_CLEAR = 3'd2,
      REDIR_BR_KEEP  = 3'd3,
      REDIR_BR_SLOT  = 3'd4
   } redirect_e;

   function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with pointer+count bookkeeping.
// keep_head collapses the queue to its current head without moving the read pointer.
module if_queue_fifo
   import if_prefetch_queue_pkg::*;
#(
   parameter int DEPTH = FETCHQ_DEPTH
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  fetch_entry_t               i_wdata,
   input  logic                       i_pop,
   input  logic                       i_keep_head,
   input  logic                       i_clear,
   output fetch_entry_t               o_head,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t    r_mem [DEPTH];
   logic [PW-1:0]   r_rd;
   logic [PW-1:0]   r_wr;
   logic [CW-1:0]   r_count;

   // Entry storage: written only on a push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_push) begin
         r_mem[r_wr] <= i_wdata;
      end
   end

   // Pointers and occupancy; clear and keep_head never coincide with a push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (i_keep_head) begin
         r_wr    <= r_rd + PW'(1'b1);
         r_count <= CW'(1'b1);
      end else begin
         if (i_push) begin
            r_wr <= r_wr + PW'(1'b1);
         end
         if (i_pop) begin
            r_rd <= r_rd + PW'(1'b1);
         end
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

   assign o_head  = r_mem[r_rd];
   assign o_count = r_count;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the PC, drives the ROM and queues {pc,inst} for decode.
// Branch redirect preserves the delay slot; exception flush discards everything.
module if_prefetch_queue
   import if_prefetch_queue_pkg::*;
#(
   parameter int          DEPTH    = FETCHQ_DEPTH,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        rst,
   output logic        rom_ce_o,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_inst_i,
   output logic        id_valid_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o,
   input  logic        id_ready_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   input  logic        flush_i,
   input  logic [31:0] new_pc_i
);

   localparam int            CW        = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   logic [31:0]   r_pc;
   logic          r_ce_q;
   logic [CW-1:0] w_count;
   fetch_entry_t  w_head;
   fetch_entry_t  w_wdata;
   logic          w_empty;
   logic          w_pop;
   logic          w_ce;
   logic          w_push;
   logic          w_clear;
   logic          w_keep;
   logic [31:0]   w_pc_next;
   redirect_e     w_redir;

   assign w_empty    = (w_count == {CW{1'b0}});
   assign id_valid_o = ~w_empty;
   assign id_pc_o    = w_empty ? ZERO_WORD : w_head.pc;
   assign id_inst_o  = w_empty ? ZERO_WORD : w_head.inst;
   assign w_pop      = id_valid_o & id_ready_i;
   // A full queue may still fetch when the head leaves in the same cycle.
   assign w_ce       = r_ce_q & ((w_count < DEPTH_CNT) | w_pop);
   assign rom_ce_o   = w_ce ? CHIP_ENABLE : CHIP_DISABLE;
   assign rom_addr_o = r_pc;
   assign w_wdata    = '{pc: r_pc, inst: rom_inst_i};

   // Classify this cycle's redirect; the delay slot is wherever the oldest post-branch fetch sits.
   always_comb begin
      w_redir = REDIR_NONE;
      if (flush_i) begin
         w_redir = REDIR_FLUSH;
      end else if (branch_flag_i) begin
         if (w_pop) begin
            w_redir = REDIR_BR_CLEAR;
         end else if (!w_empty) begin
            w_redir = REDIR_BR_KEEP;
         end else begin
            w_redir = REDIR_BR_SLOT;
         end
      end else begin
         w_redir = REDIR_NONE;
      end
   end

   // Queue control and next-PC selection from the redirect class.
   always_comb begin
      w_push    = 1'b0;
      w_clear   = 1'b0;
      w_keep    = 1'b0;
      w_pc_next = r_pc;
      case (w_redir)
         REDIR_NONE: begin
            w_push    = w_ce;
            w_pc_next = w_ce ? next_seq_pc(r_pc) : r_pc;
         end
         REDIR_FLUSH: begin
            w_clear   = 1'b1;
            w_pc_next = new_pc_i;
         end
         REDIR_BR_CLEAR: begin
            w_clear   = 1'b1;
            w_pc_next = branch_target_i;
         end
         REDIR_BR_KEEP: begin
            w_keep    = 1'b1;
            w_pc_next = branch_target_i;
         end
         REDIR_BR_SLOT: begin
            w_push    = w_ce;
            w_pc_next = branch_target_i;
         end
         default: begin
            w_push    = 1'b0;
            w_pc_next = r_pc;
         end
      endcase
   end

   // PC and fetch-enable state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc   <= RESET_PC;
         r_ce_q <= CHIP_DISABLE;
      end else begin
         r_pc   <= w_pc_next;
         r_ce_q <= CHIP_ENABLE;
      end
   end

   if_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_wdata     (w_wdata),
      .i_pop       (w_pop),
      .i_keep_head (w_keep),
      .i_clear     (w_clear),
      .o_head      (w_head),
      .o_count     (w_count)
   );

endmodule
